// File: rtl/regwrite_arbiter.sv
// regwrite_arbiter: shares the register-file write port between the ALU (A) and
// memory (B) writebacks. Define REGWR_ARB_RR_EN for round-robin contention.
module regwrite_arbiter #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 3,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [3:0]        starve_cnt_o
);

  localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

  // Reject starvation limits the 4-bit counter cannot represent
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : gBadStarveMax
    $error("regwrite_arbiter: STARVE_MAX must be within 1..15");
  end

  logic              grantA_s;
  logic              grantB_s;
  logic              favorB_s;
  logic              wrEn_r;
  logic [ADDR_W-1:0] wrAddr_r;
  logic [DATA_W-1:0] wrData_r;

`ifdef REGWR_ARB_RR_EN
  logic lastGrant_r;

  // Contention goes to whoever did not win most recently (0 = A, 1 = B)
  always_comb begin
    favorB_s = ~lastGrant_r;
  end

  // Track the most recent winner, including uncontended grants
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastGrant_r <= 1'b0;
    end else if (grantB_s) begin
      lastGrant_r <= 1'b1;
    end else if (grantA_s) begin
      lastGrant_r <= 1'b0;
    end else begin
      lastGrant_r <= lastGrant_r;
    end
  end

  assign starve_cnt_o = 4'd0;
`else
  logic [3:0] starveCnt_r;
  logic [3:0] starveNext_s;

  // A has priority until B has lost STARVE_MAX contended cycles in a row
  always_comb begin
    favorB_s = (starveCnt_r == STARVE_MAX_C);
  end

  // Count B's contended losses; any B win or idle B restarts the count
  always_comb begin
    starveNext_s = starveCnt_r;
    if (grantB_s || !b_valid) begin
      starveNext_s = 4'd0;
    end else if (grantA_s) begin
      if (starveCnt_r >= STARVE_MAX_C) begin
        starveNext_s = STARVE_MAX_C;
      end else begin
        starveNext_s = starveCnt_r + 4'd1;
      end
    end else begin
      starveNext_s = starveCnt_r;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starveCnt_r <= 4'd0;
    end else begin
      starveCnt_r <= starveNext_s;
    end
  end

  assign starve_cnt_o = starveCnt_r;
`endif

  // Grant decision; readies stay low for the whole reset assertion
  always_comb begin
    grantA_s = 1'b0;
    grantB_s = 1'b0;
    if (rst) begin
      grantA_s = 1'b0;
      grantB_s = 1'b0;
    end else if (a_valid && b_valid) begin
      if (favorB_s) begin
        grantB_s = 1'b1;
      end else begin
        grantA_s = 1'b1;
      end
    end else if (a_valid) begin
      grantA_s = 1'b1;
    end else if (b_valid) begin
      grantB_s = 1'b1;
    end else begin
      grantA_s = 1'b0;
      grantB_s = 1'b0;
    end
  end

  assign a_ready = grantA_s;
  assign b_ready = grantB_s;

  // Write-port register: one-cycle wr_en pulse per transfer, addr/data hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrEn_r   <= 1'b0;
      wrAddr_r <= '0;
      wrData_r <= '0;
    end else if (grantA_s) begin
      wrEn_r   <= 1'b1;
      wrAddr_r <= a_addr;
      wrData_r <= a_data;
    end else if (grantB_s) begin
      wrEn_r   <= 1'b1;
      wrAddr_r <= b_addr;
      wrData_r <= b_data;
    end else begin
      wrEn_r   <= 1'b0;
      wrAddr_r <= wrAddr_r;
      wrData_r <= wrData_r;
    end
  end

  assign wr_en   = wrEn_r;
  assign wr_addr = wrAddr_r;
  assign wr_data = wrData_r;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// tb_regwrite_arbiter: directed and random checks of regwrite_arbiter against a
// grant-rule reference model and a falling-edge register-file model.
module tb_regwrite_arbiter;
  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 3;
  localparam int STARVE_MAX = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_valid, b_valid;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_data, b_data;
  logic              a_ready, b_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [3:0]        starve_cnt_o;

  regwrite_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .starve_cnt_o(starve_cnt_o)
  );

  always #5 clk = ~clk;

  // Register file under test captures on the falling edge
  logic [DATA_W-1:0] rf [0:7];
  always @(negedge clk) begin
    if (wr_en === 1'b1) rf[wr_addr] <= wr_data;
  end

  int nChecks = 0;
  int nFail   = 0;

  // Reference model state
  int                mLoss = 0;
  bit                mLast = 1'b0;
  logic              mWrEn = 1'b0;
  logic [ADDR_W-1:0] mWrAddr = '0;
  logic [DATA_W-1:0] mWrData = '0;
  logic [DATA_W-1:0] mRf [0:7];
  bit                aWon = 1'b0;
  bit                bWon = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit av, input logic [2:0] aa, input logic [7:0] ad,
                      input bit bv, input logic [2:0] ba, input logic [7:0] bd);
    bit aW, bW;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #2;
`ifdef REGWR_ARB_RR_EN
    bW = bv && (!av || !mLast);
`else
    bW = bv && (!av || mLoss == STARVE_MAX);
`endif
    aW = av && !bW;
    chk("a_ready", a_ready, aW);
    chk("b_ready", b_ready, bW);
    @(posedge clk);
    #1;
    if (bW || !bv) mLoss = 0;
    else if (aW) mLoss = (mLoss + 1 > STARVE_MAX) ? STARVE_MAX : mLoss + 1;
    if (aW) mLast = 1'b0;
    if (bW) mLast = 1'b1;
    mWrEn = aW || bW;
    if (aW) begin mWrAddr = aa; mWrData = ad; mRf[aa] = ad; end
    if (bW) begin mWrAddr = ba; mWrData = bd; mRf[ba] = bd; end
    chk("wr_en", wr_en, mWrEn);
    chk("wr_addr", wr_addr, mWrAddr);
    chk("wr_data", wr_data, mWrData);
`ifdef REGWR_ARB_RR_EN
    chk("starve_cnt", starve_cnt_o, 32'd0);
`else
    chk("starve_cnt", starve_cnt_o, mLoss);
`endif
    aWon = aW;
    bWon = bW;
  endtask

  task automatic idle();
    step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
  endtask

  initial begin
    logic              av, bv;
    logic [ADDR_W-1:0] aa, ba;
    logic [DATA_W-1:0] ad, bd;
    logic [DATA_W-1:0] saved6;

    rst = 1'b1;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    #7;
    chk("rst_wr_en", wr_en, 32'd0);
    chk("rst_wr_addr", wr_addr, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_starve", starve_cnt_o, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;

    // Single A write, then confirm register 5 after the falling edge
    step(1'b1, 3'd5, 8'h3C, 1'b0, 3'd0, 8'h00);
    chk("singleA_en", wr_en, 32'd1);
    chk("singleA_data", wr_data, 32'h3C);
    idle();
    @(negedge clk); #1;
    chk("rf5", rf[5], 32'h3C);

    // Register 6 holds zero before the dropped-write test
    step(1'b1, 3'd6, 8'h00, 1'b0, 3'd0, 8'h00);
    idle();

    // Contention: A,A,A,B pattern with starvation 1,2,3,0
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22);
`ifndef REGWR_ARB_RR_EN
      chk("cont_grantB", bWon, (i % 4 == 3) ? 32'd1 : 32'd0);
      chk("cont_starve", starve_cnt_o, (i % 4 == 3) ? 32'd0 : 32'(i % 4 + 1));
`endif
    end

    // Mid-cycle reset drops the pulse in flight and clears everything at once
    saved6 = mRf[6];
    step(1'b1, 3'd6, 8'h99, 1'b1, 3'd3, 8'h77);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_wr_en", wr_en, 32'd0);
    chk("mid_rst_wr_addr", wr_addr, 32'd0);
    chk("mid_rst_wr_data", wr_data, 32'd0);
    chk("mid_rst_starve", starve_cnt_o, 32'd0);
    chk("mid_rst_a_ready", a_ready, 32'd0);
    chk("mid_rst_b_ready", b_ready, 32'd0);
    a_valid = 1'b0; b_valid = 1'b0;
    mLoss = 0; mLast = 1'b0; mWrEn = 1'b0; mWrAddr = '0; mWrData = '0;
    mRf[6] = saved6;
    @(negedge clk); #1;
    chk("rf6_no_write", rf[6], 32'h00);
    rst = 1'b0;
    idle();

    // Same-address conflict: A first, then B's data is final
    step(1'b1, 3'd4, 8'hAA, 1'b1, 3'd4, 8'h55);
    if (aWon) step(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 8'h55);
    else      step(1'b1, 3'd4, 8'hAA, 1'b0, 3'd0, 8'h00);
    idle();
    @(negedge clk); #1;
`ifndef REGWR_ARB_RR_EN
    chk("rf4_final", rf[4], 32'h55);
`else
    chk("rf4_final", rf[4], mRf[4]);
`endif

    // Back-to-back B: four consecutive pulses, no bubbles
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 8'(i + 1));
      chk("b2b_en", wr_en, 32'd1);
      chk("b2b_data", wr_data, 32'(i + 1));
    end
    idle();

    // Random traffic; pending requests hold addr/data until accepted
    av = 1'b0; bv = 1'b0; aa = '0; ba = '0; ad = '0; bd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!(av && !aWon)) begin
        av = ($urandom_range(0, 9) < 6);
        aa = 3'($urandom); ad = 8'($urandom);
      end
      if (!(bv && !bWon)) begin
        bv = ($urandom_range(0, 9) < 6);
        ba = 3'($urandom); bd = 8'($urandom);
      end
      step(av, aa, ad, bv, ba, bd);
    end
    idle();
    @(negedge clk); #1;
    for (int r = 0; r < 8; r++) chk("rf_final", rf[r], mRf[r]);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
